// File: rtl/mantissa_divider_seq.sv
// Restoring divider for (1.a)/(1.b), BITS_PER_CYCLE quotient bits per clock; done pulses
// ceil((MAN_WIDTH+3)/BITS_PER_CYCLE)+1 clocks after an accepted start; start is ignored while busy.
module mantissa_divider_seq #(
  parameter int MAN_WIDTH      = 23,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MAN_WIDTH-1:0] a_man,
  input  logic [MAN_WIDTH-1:0] b_man,
  output logic                 busy,
  output logic                 done,
  output logic [MAN_WIDTH-1:0] frac,
  output logic                 guard,
  output logic                 sticky,
  output logic                 carry_down
);

  localparam int NQ = MAN_WIDTH + 3;
  localparam int RW = MAN_WIDTH + 2;
  localparam int CW = $clog2(NQ + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_n;
  logic [RW-1:0]   r_q;
  logic [RW-1:0]   r_n;
  logic [RW-1:0]   d_q;
  logic [NQ-1:0]   q_q;
  logic [NQ-1:0]   q_n;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_n;
  logic            calc_last;
  logic            accept;

  logic [MAN_WIDTH-1:0] frac_n;
  logic                 guard_n;
  logic                 sticky_n;
  logic                 carry_down_n;

  assign accept = (state_q == IDLE) && start && !abort;
  assign busy   = (state_q == CALC) || (state_q == NORM);

  // Unrolled restoring steps; the count guard stops the last clock short when
  // BITS_PER_CYCLE does not divide NQ.
  always_comb begin
    r_n   = r_q;
    q_n   = q_q;
    cnt_n = cnt_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (cnt_n < CW'(NQ)) begin
        if (r_n >= d_q) begin
          r_n = r_n - d_q;
          q_n = {q_n[NQ-2:0], 1'b1};
        end else begin
          q_n = {q_n[NQ-2:0], 1'b0};
        end
        r_n   = r_n << 1;
        cnt_n = cnt_n + 1'b1;
      end
    end
    calc_last = (cnt_n == CW'(NQ));
  end

  always_comb begin
    if (q_q[NQ-1]) begin
      frac_n       = q_q[NQ-2:2];
      guard_n      = q_q[1];
      sticky_n     = q_q[0] | (r_q != '0);
      carry_down_n = 1'b0;
    end else begin
      frac_n       = q_q[NQ-3:1];
      guard_n      = q_q[0];
      sticky_n     = (r_q != '0);
      carry_down_n = 1'b1;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (accept) state_n = CALC;
      CALC: begin
        if (abort)          state_n = IDLE;
        else if (calc_last) state_n = NORM;
      end
      NORM:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      d_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      done       <= 1'b0;
      frac       <= '0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      carry_down <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        r_q   <= {1'b0, 1'b1, a_man};
        d_q   <= {1'b0, 1'b1, b_man};
        q_q   <= '0;
        cnt_q <= '0;
      end else if (state_q == CALC && !abort) begin
        r_q   <= r_n;
        q_q   <= q_n;
        cnt_q <= cnt_n;
      end else if (state_q == NORM && !abort) begin
        frac       <= frac_n;
        guard      <= guard_n;
        sticky     <= sticky_n;
        carry_down <= carry_down_n;
        done       <= 1'b1;
      end
    end
  end

endmodule
